// File: rtl/video_pkg.sv
// Shared definitions for the video engine write initiator: table selects,
// default table depths, FSM state encoding and per-table write-data masking.
package video_pkg;

  // Engine table selects carried on w_param
  localparam logic [1:0] P_PALDEF  = 2'd0;
  localparam logic [1:0] P_TILEDEF = 2'd1;
  localparam logic [1:0] P_PALMAP  = 2'd2;
  localparam logic [1:0] P_TILEMAP = 2'd3;

  // Default engine table sizes
  localparam int PAL_DEPTH_DEF  = 16;
  localparam int TILE_WORDS_DEF = 256;
  localparam int MAP_DEPTH_DEF  = 1200;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2
  } state_e;

  // Each engine table only stores part of the 16-bit word; clear the unused
  // upper bits so the engine never sees stray data.
  function automatic logic [15:0] mask_val(input logic [1:0] param,
                                           input logic [15:0] v);
    logic [15:0] r;
    case (param)
      P_PALDEF:  r = {4'b0, v[11:0]};
      P_TILEDEF: r = v;
      P_PALMAP:  r = {8'b0, v[7:0]};
      P_TILEMAP: r = {10'b0, v[5:0]};
      default:   r = v;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/video_writer_if.sv
// Command, stream-data, engine-write and status signals of video_writer.
// master: the writer itself; slave: CPU decode / data source / engine side.
interface video_writer_if;
  import video_pkg::*;

  // Command channel
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_op;
  logic [1:0]  cmd_param;
  logic [10:0] cmd_index;
  logic [10:0] cmd_count;
  logic [15:0] cmd_val;

  // Stream data channel
  logic        data_valid;
  logic        data_ready;
  logic [15:0] data_val;

  // Engine write port
  logic        wen;
  logic [1:0]  w_param;
  logic [10:0] w_index;
  logic [15:0] w_val;

  // Status
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    input  cmd_valid, cmd_op, cmd_param, cmd_index, cmd_count, cmd_val,
    input  data_valid, data_val,
    output cmd_ready, data_ready,
    output wen, w_param, w_index, w_val,
    output busy, done, err
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_param, cmd_index, cmd_count, cmd_val,
    output data_valid, data_val,
    input  cmd_ready, data_ready,
    input  wen, w_param, w_index, w_val,
    input  busy, done, err
  );

endinterface

// File: rtl/video_writer.sv
// Command-driven write initiator for the tile/palette video engine.
// Accepts fill/stream block commands, range-checks them against the table
// sizes and issues one registered engine write per cycle.
module video_writer
  import video_pkg::*;
#(
  parameter int PAL_DEPTH  = PAL_DEPTH_DEF,
  parameter int TILE_WORDS = TILE_WORDS_DEF,
  parameter int MAP_DEPTH  = MAP_DEPTH_DEF
) (
  input  logic           clk,
  input  logic           resetn,
  video_writer_if.master bus
);

  // Table size for a given table select, widened to the 12-bit check width.
  function automatic logic [11:0] limit_of(input logic [1:0] p);
    logic [11:0] r;
    case (p)
      P_PALDEF:  r = 12'(PAL_DEPTH);
      P_TILEDEF: r = 12'(TILE_WORDS);
      default:   r = 12'(MAP_DEPTH);
    endcase
    return r;
  endfunction

  state_e      state_q, state_d;
  logic [10:0] rem_q, rem_d;
  logic [10:0] idx_q, idx_d;
  logic [1:0]  param_q, param_d;
  logic [15:0] val_q, val_d;

  logic        wen_q, wen_d;
  logic [1:0]  wparam_q, wparam_d;
  logic [10:0] windex_q, windex_d;
  logic [15:0] wval_q, wval_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic [11:0] cmd_end;
  logic [11:0] cmd_limit;
  logic        cmd_ready_w;
  logic        data_ready_w;
  logic        data_fire;

  // The sum is taken at 12 bits so index+count can never wrap past the limit.
  assign cmd_end      = {1'b0, bus.cmd_index} + {1'b0, bus.cmd_count};
  assign cmd_limit    = limit_of(bus.cmd_param);
  assign cmd_ready_w  = (state_q == IDLE) && resetn;
  assign data_ready_w = (state_q == STREAM) && (rem_q != 11'd0);
  assign data_fire    = bus.data_valid && data_ready_w;

  // Next-state, counter and engine-write decode.
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    idx_d    = idx_q;
    param_d  = param_q;
    val_d    = val_q;
    wen_d    = 1'b0;
    wparam_d = wparam_q;
    windex_d = windex_q;
    wval_d   = wval_q;
    done_d   = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid && cmd_ready_w) begin
          if (cmd_end > cmd_limit) begin
            err_d = 1'b1;
          end else if (bus.cmd_count == 11'd0) begin
            done_d = 1'b1;
          end else begin
            param_d = bus.cmd_param;
            val_d   = mask_val(bus.cmd_param, bus.cmd_val);
            if (!bus.cmd_op) begin
              // Fill issues its first write on the acceptance edge so that
              // back-to-back commands run without bubbles.
              wen_d    = 1'b1;
              wparam_d = bus.cmd_param;
              windex_d = bus.cmd_index;
              wval_d   = mask_val(bus.cmd_param, bus.cmd_val);
              idx_d    = bus.cmd_index + 11'd1;
              rem_d    = bus.cmd_count - 11'd1;
              if (bus.cmd_count == 11'd1) begin
                done_d = 1'b1;
              end else begin
                state_d = FILL;
              end
            end else begin
              idx_d   = bus.cmd_index;
              rem_d   = bus.cmd_count;
              state_d = STREAM;
            end
          end
        end
      end

      FILL: begin
        wen_d    = 1'b1;
        wparam_d = param_q;
        windex_d = idx_q;
        wval_d   = val_q;
        idx_d    = idx_q + 11'd1;
        rem_d    = rem_q - 11'd1;
        if (rem_q == 11'd1) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end

      STREAM: begin
        if (data_fire) begin
          wen_d    = 1'b1;
          wparam_d = param_q;
          windex_d = idx_q;
          wval_d   = mask_val(param_q, bus.data_val);
          idx_d    = idx_q + 11'd1;
          rem_d    = rem_q - 11'd1;
          if (rem_q == 11'd1) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // FSM state and command counters; reset abandons any command in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      rem_q   <= '0;
      idx_q   <= '0;
      param_q <= '0;
      val_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      param_q <= param_d;
      val_q   <= val_d;
    end
  end

  // Registered engine write port and status pulses.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wen_q    <= 1'b0;
      wparam_q <= '0;
      windex_q <= '0;
      wval_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      wen_q    <= wen_d;
      wparam_q <= wparam_d;
      windex_q <= windex_d;
      wval_q   <= wval_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bus.cmd_ready  = cmd_ready_w;
  assign bus.data_ready = data_ready_w;
  assign bus.wen        = wen_q;
  assign bus.w_param    = wparam_q;
  assign bus.w_index    = windex_q;
  assign bus.w_val      = wval_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = done_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_video_writer.sv
// Directed testbench for video_writer: fill, stream, range errors,
// zero-count, back-to-back commands and reset in the middle of a fill.
module tb_video_writer;

  logic clk;
  logic resetn;
  int   checks;
  int   errors;

  video_writer_if vif();

  video_writer dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (vif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Offer one command; entered just after a rising edge, returns 1 ns after
  // the accepting edge.
  task automatic send_cmd(input logic op, input logic [1:0] p,
                          input logic [10:0] idx, input logic [10:0] cnt,
                          input logic [15:0] v);
    vif.cmd_op    = op;
    vif.cmd_param = p;
    vif.cmd_index = idx;
    vif.cmd_count = cnt;
    vif.cmd_val   = v;
    vif.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    vif.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({vif.wen, vif.busy, vif.done, vif.err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_status: got wen/busy/done/err=%b required 0000",
               {vif.wen, vif.busy, vif.done, vif.err});
    end
    checks++;
    if ({vif.w_param, vif.w_index, vif.w_val} !== 29'd0) begin
      errors++;
      $display("FAIL reset_wport: got %h/%h/%h required 0/0/0",
               vif.w_param, vif.w_index, vif.w_val);
    end
    checks++;
    if ({vif.cmd_ready, vif.data_ready} !== 2'b00) begin
      errors++;
      $display("FAIL reset_ready: got cmd/data=%b required 00",
               {vif.cmd_ready, vif.data_ready});
    end
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(negedge clk);
    checks++;
    if (vif.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b required 1", vif.cmd_ready);
    end
  endtask

  task automatic test_fill();
    logic [31:0] got;
    logic [31:0] exp;
    @(posedge clk);
    #1;
    send_cmd(1'b0, 2'd2, 11'd0, 11'd1200, 16'hFFA5);
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      got = {vif.wen, vif.busy, vif.cmd_ready, vif.done, vif.w_param,
             vif.w_index, vif.w_val};
      exp = {1'b1, (i != 1199), (i == 1199), (i == 1199), 2'd2,
             11'(i), 16'h00A5};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL fill_write[%0d]: got %h required %h", i, got, exp);
      end
    end
    @(negedge clk);
    checks++;
    if ({vif.wen, vif.done, vif.cmd_ready} !== 3'b001) begin
      errors++;
      $display("FAIL fill_after: got wen/done/cmd_ready=%b required 001",
               {vif.wen, vif.done, vif.cmd_ready});
    end
  endtask

  task automatic test_stream();
    logic        vld  [0:5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] word [0:5] = '{16'h1111, 16'h2222, 16'h0000, 16'h0000,
                                16'h3333, 16'h4444};
    logic        e_wen  [1:6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [10:0] e_idx  [1:6] = '{11'd4, 11'd5, 11'd5, 11'd5, 11'd6, 11'd7};
    logic [15:0] e_val  [1:6] = '{16'h1111, 16'h2222, 16'h2222, 16'h2222,
                                  16'h3333, 16'h4444};
    logic        e_done [1:6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [29:0] got;
    logic [29:0] exp;
    @(posedge clk);
    #1;
    send_cmd(1'b1, 2'd1, 11'd4, 11'd4, 16'hDEAD);
    vif.data_valid = vld[0];
    vif.data_val   = word[0];
    @(negedge clk);
    checks++;
    if ({vif.wen, vif.busy, vif.data_ready, vif.cmd_ready} !== 4'b0110) begin
      errors++;
      $display("FAIL stream_start: got wen/busy/dready/cready=%b required 0110",
               {vif.wen, vif.busy, vif.data_ready, vif.cmd_ready});
    end
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk);
      #1;
      vif.data_valid = (c < 6) ? vld[c] : 1'b0;
      vif.data_val   = (c < 6) ? word[c] : 16'h0000;
      @(negedge clk);
      got = {vif.wen, vif.done, vif.w_index, vif.w_val, vif.w_param};
      exp = {e_wen[c], e_done[c], e_idx[c], e_val[c], 2'd1};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL stream_cycle[%0d]: got %h required %h", c, got, exp);
      end
    end
    checks++;
    if ({vif.data_ready, vif.cmd_ready, vif.busy} !== 3'b010) begin
      errors++;
      $display("FAIL stream_end: got dready/cready/busy=%b required 010",
               {vif.data_ready, vif.cmd_ready, vif.busy});
    end
    @(negedge clk);
    checks++;
    if ({vif.wen, vif.done} !== 2'b00) begin
      errors++;
      $display("FAIL stream_after: got wen/done=%b required 00",
               {vif.wen, vif.done});
    end
  endtask

  task automatic test_range();
    @(posedge clk);
    #1;
    send_cmd(1'b0, 2'd0, 11'd14, 11'd4, 16'h1234);
    @(negedge clk);
    checks++;
    if ({vif.err, vif.done, vif.wen, vif.busy, vif.cmd_ready} !== 5'b10001) begin
      errors++;
      $display("FAIL range_err: got err/done/wen/busy/cready=%b required 10001",
               {vif.err, vif.done, vif.wen, vif.busy, vif.cmd_ready});
    end
    @(negedge clk);
    checks++;
    if ({vif.err, vif.wen, vif.busy} !== 3'b000) begin
      errors++;
      $display("FAIL range_err_pulse: got err/wen/busy=%b required 000",
               {vif.err, vif.wen, vif.busy});
    end
    // index+count exactly equal to the table size is legal
    @(posedge clk);
    #1;
    send_cmd(1'b0, 2'd3, 11'd1199, 11'd1, 16'hFFFF);
    @(negedge clk);
    checks++;
    if ({vif.err, vif.wen, vif.done, vif.w_param, vif.w_index, vif.w_val}
        !== {1'b0, 1'b1, 1'b1, 2'd3, 11'd1199, 16'h003F}) begin
      errors++;
      $display("FAIL range_edge: got err/wen/done=%b idx=%0d val=%h required 011 1199 003f",
               {vif.err, vif.wen, vif.done}, vif.w_index, vif.w_val);
    end
    @(negedge clk);
    checks++;
    if ({vif.wen, vif.done} !== 2'b00) begin
      errors++;
      $display("FAIL range_edge_single: got wen/done=%b required 00",
               {vif.wen, vif.done});
    end
    // one past the end of the tile table in stream mode
    @(posedge clk);
    #1;
    send_cmd(1'b1, 2'd1, 11'd253, 11'd4, 16'h0000);
    @(negedge clk);
    checks++;
    if ({vif.err, vif.busy, vif.data_ready} !== 3'b100) begin
      errors++;
      $display("FAIL range_stream: got err/busy/dready=%b required 100",
               {vif.err, vif.busy, vif.data_ready});
    end
  endtask

  task automatic test_zero_count();
    @(posedge clk);
    #1;
    send_cmd(1'b0, 2'd3, 11'd5, 11'd0, 16'h0007);
    @(negedge clk);
    checks++;
    if ({vif.done, vif.err, vif.wen, vif.cmd_ready, vif.busy} !== 5'b10010) begin
      errors++;
      $display("FAIL zero_done: got done/err/wen/cready/busy=%b required 10010",
               {vif.done, vif.err, vif.wen, vif.cmd_ready, vif.busy});
    end
    @(negedge clk);
    checks++;
    if ({vif.done, vif.wen} !== 2'b00) begin
      errors++;
      $display("FAIL zero_pulse: got done/wen=%b required 00",
               {vif.done, vif.wen});
    end
  endtask

  task automatic test_back_to_back();
    @(posedge clk);
    #1;
    send_cmd(1'b0, 2'd0, 11'd0, 11'd2, 16'hABCD);
    @(negedge clk);
    checks++;
    if ({vif.wen, vif.done, vif.w_param, vif.w_index, vif.w_val}
        !== {1'b1, 1'b0, 2'd0, 11'd0, 16'h0BCD}) begin
      errors++;
      $display("FAIL b2b_w0: got wen/done=%b p=%0d idx=%0d val=%h required 10 0 0 0bcd",
               {vif.wen, vif.done}, vif.w_param, vif.w_index, vif.w_val);
    end
    @(posedge clk);
    #1;
    vif.cmd_op    = 1'b0;
    vif.cmd_param = 2'd3;
    vif.cmd_index = 11'd10;
    vif.cmd_count = 11'd1;
    vif.cmd_val   = 16'hABCD;
    vif.cmd_valid = 1'b1;
    @(negedge clk);
    checks++;
    if ({vif.wen, vif.done, vif.cmd_ready, vif.w_index, vif.w_val}
        !== {1'b1, 1'b1, 1'b1, 11'd1, 16'h0BCD}) begin
      errors++;
      $display("FAIL b2b_w1: got wen/done/cready=%b idx=%0d val=%h required 111 1 0bcd",
               {vif.wen, vif.done, vif.cmd_ready}, vif.w_index, vif.w_val);
    end
    @(posedge clk);
    #1;
    vif.cmd_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({vif.wen, vif.done, vif.w_param, vif.w_index, vif.w_val}
        !== {1'b1, 1'b1, 2'd3, 11'd10, 16'h000D}) begin
      errors++;
      $display("FAIL b2b_w2: got wen/done=%b p=%0d idx=%0d val=%h required 11 3 10 000d",
               {vif.wen, vif.done}, vif.w_param, vif.w_index, vif.w_val);
    end
    @(negedge clk);
    checks++;
    if ({vif.wen, vif.done} !== 2'b00) begin
      errors++;
      $display("FAIL b2b_after: got wen/done=%b required 00", {vif.wen, vif.done});
    end
  endtask

  task automatic test_reset_mid_fill();
    logic [1:0] seen;
    @(posedge clk);
    #1;
    send_cmd(1'b0, 2'd2, 11'd100, 11'd100, 16'h0042);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({vif.wen, vif.w_index} !== {1'b1, 11'(100 + i)}) begin
        errors++;
        $display("FAIL rst_fill_write[%0d]: got wen=%b idx=%0d required 1 %0d",
                 i, vif.wen, vif.w_index, 100 + i);
      end
    end
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if ({vif.wen, vif.busy, vif.done, vif.err, vif.cmd_ready, vif.data_ready}
        !== 6'b000000) begin
      errors++;
      $display("FAIL rst_async_ctl: got wen/busy/done/err/cready/dready=%b required 000000",
               {vif.wen, vif.busy, vif.done, vif.err, vif.cmd_ready, vif.data_ready});
    end
    checks++;
    if ({vif.w_param, vif.w_index, vif.w_val} !== 29'd0) begin
      errors++;
      $display("FAIL rst_async_wport: got %h/%h/%h required 0/0/0",
               vif.w_param, vif.w_index, vif.w_val);
    end
    @(posedge clk);
    #1;
    resetn = 1'b1;
    seen = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      seen = seen | {vif.wen, vif.done};
    end
    checks++;
    if ({seen, vif.cmd_ready, vif.busy} !== 4'b0010) begin
      errors++;
      $display("FAIL rst_release: got seen wen/done=%b cready/busy=%b required 00 10",
               seen, {vif.cmd_ready, vif.busy});
    end
    @(posedge clk);
    #1;
    send_cmd(1'b0, 2'd1, 11'd3, 11'd1, 16'h9876);
    @(negedge clk);
    checks++;
    if ({vif.wen, vif.done, vif.w_param, vif.w_index, vif.w_val}
        !== {1'b1, 1'b1, 2'd1, 11'd3, 16'h9876}) begin
      errors++;
      $display("FAIL rst_next_cmd: got wen/done=%b p=%0d idx=%0d val=%h required 11 1 3 9876",
               {vif.wen, vif.done}, vif.w_param, vif.w_index, vif.w_val);
    end
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    resetn         = 1'b0;
    vif.cmd_valid  = 1'b0;
    vif.cmd_op     = 1'b0;
    vif.cmd_param  = 2'd0;
    vif.cmd_index  = 11'd0;
    vif.cmd_count  = 11'd0;
    vif.cmd_val    = 16'h0000;
    vif.data_valid = 1'b0;
    vif.data_val   = 16'h0000;

    test_reset();
    test_fill();
    test_stream();
    test_range();
    test_zero_count();
    test_back_to_back();
    test_reset_mid_fill();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_writer.md
Name: video_writer

Overview:
Command-driven write initiator for the tile/palette video engine's write port (wen, w_param, w_index, w_val). It accepts block commands from the CPU side and emits one engine write per cycle. Fill mode repeats a single value; stream mode forwards words from a valid/ready data channel. It sits between the CPU bus decode and the video block, and it range-checks every command against the engine table sizes.

Parameters:
PAL_DEPTH, 16, paldef entries (w_param 0)
TILE_WORDS, 256, tiledef 16-bit words, 64 tiles x 4 (w_param 1)
MAP_DEPTH, 1200, palmap/tilemap entries, 40x30 (w_param 2, 3)

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when valid&ready
cmd_op  in  1  0=fill, 1=stream
cmd_param  in  2  target table (0 paldef, 1 tiledef, 2 palmap, 3 tilemap)
cmd_index  in  11  first index
cmd_count  in  11  number of writes (0 legal)
cmd_val  in  16  fill value (ignored in stream)
data_valid  in  1  stream word offered
data_ready  out  1  stream word accepted when valid&ready
data_val  in  16  stream word
wen  out  1  engine write strobe
w_param  out  2  engine table select
w_index  out  11  engine index
w_val  out  16  engine write data, masked per table
busy  out  1  command in progress
done  out  1  one-cycle completion pulse
err  out  1  one-cycle range-error pulse

Behaviour:
- Reset (async, resetn=0): state IDLE. wen, w_param, w_index, w_val, busy, done and err all 0. data_ready=0, cmd_ready=0 while resetn=0.
- Reset mid-command abandons the command immediately. No further writes. No done pulse.
- States:
  - IDLE: cmd_ready=1.
  - FILL, STREAM: cmd_ready=0.
  - busy=1 in FILL and STREAM.
- Acceptance: on cmd_valid&cmd_ready, latch param, index, count, val and op. The limit is PAL_DEPTH, TILE_WORDS or MAP_DEPTH according to param.
  - If index+count > limit (12-bit sum, no wrap): no writes. err=1 for the next cycle. Stay IDLE.
  - Else if count==0: no writes. done=1 for the next cycle. Stay IDLE.
  - Else: go to FILL or STREAM according to op.
- All engine outputs are registered. wen is high for exactly one cycle per write. w_param, w_index and w_val are valid while wen=1 and hold their last value otherwise.
- FILL:
  - The first wen is in the cycle after acceptance.
  - Then wen is asserted on count consecutive cycles, with w_index = index, index+1, …, index+count-1.
- STREAM:
  - data_ready = (state==STREAM) & (remaining>0), combinational from the registered state.
  - Each handshake at edge n produces wen at cycle n+1 with that word and the next index.
  - Gaps in data_valid produce gaps in wen. Order is preserved and no word is dropped or duplicated.
- Completion:
  - done=1 in the same cycle as the final wen.
  - The state is IDLE in that cycle, so cmd_ready=1 and a new command can be accepted.
  - The next command's first wen follows in the next cycle, so back-to-back commands have zero bubbles.
- w_val masking, applied to both fill and stream data:
  - param 0: {4'b0, v[11:0]}
  - param 1: v unmasked
  - param 2: {8'b0, v[7:0]}
  - param 3: {10'b0, v[5:0]}
- The remaining counter is 11 bits and decrements once per write. The index counter increments once per write. The range check guarantees the index never exceeds limit-1.
- done and err are never asserted in the same cycle.

Decomposition:
- Shared package video_pkg:
  - table-select constants P_PALDEF=0, P_TILEDEF=1, P_PALMAP=2, P_TILEMAP=3
  - default depths 16/256/1200
  - state enum IDLE/FILL/STREAM
  - mask function for w_val
- No sub-module. The FSM, counters and output register are small enough for a single module.

Test Plan:
- Fill: param 2, index 0, count 1200, val 0xFFA5 → 1200 consecutive wen, w_index 0..1199, w_val 0x00A5; done coincides with the write at index 1199; then cmd_ready=1.
- Stream: param 1, index 4, count 4, words 0x1111/0x2222/0x3333/0x4444 with data_valid low for 2 cycles after the second word → wen at indices 4..7 with those values, one idle gap, done with the write at index 7.
- Range error: param 0, index 14, count 4 → err pulse 1 cycle after acceptance, no wen, busy stays 0; same with param 3, index 1199, count 1 → accepted, single write at index 1199.
- Zero count: param 3, count 0 → done pulse next cycle, no wen, cmd_ready stays 1.
- Back-to-back: fill param 0, index 0, count 2 followed immediately by fill param 3, index 10, count 1 → wen on 3 consecutive cycles, indices 0, 1, 10; tilemap value masked to 6 bits.
- Reset mid-fill: resetn low after the 5th write of a count-100 fill → wen drops asynchronously; all outputs 0; no done; after release, IDLE with cmd_ready=1 and the next command behaves normally.
